// File: rtl/timer_counter.sv
// Memory-mapped countdown timer: CTRL/PRESET/COUNT registers on the CPU data bus,
// raising an interrupt request when a programmed count expires.
module timer_counter #(
    parameter int COUNT_W = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  addr,
    input  logic        we,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_CNT  = 2'd2,
        ST_INT  = 2'd3
    } state_t;

    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_PRESET = 2'd1;
    localparam logic [1:0] ADDR_COUNT  = 2'd2;
    localparam logic [1:0] MODE_AUTO   = 2'b01;

    state_t               state_r, state_s;
    logic [3:0]           ctrl_r, ctrl_s;
    logic [COUNT_W-1:0]   preset_r, preset_s;
    logic [COUNT_W-1:0]   count_r, count_s;
    logic                 irq_flag_r, irq_flag_s;
    logic                 irq_r;

    // Next-state and register-update logic; a CTRL write overrides the FSM.
    always_comb begin
        state_s    = state_r;
        ctrl_s     = ctrl_r;
        preset_s   = preset_r;
        count_s    = count_r;
        irq_flag_s = irq_flag_r;
        if (we && (addr == ADDR_CTRL)) begin
            ctrl_s     = wdata[3:0];
            irq_flag_s = 1'b0;
            state_s    = ST_IDLE;
        end else begin
            if (we && (addr == ADDR_PRESET)) begin
                preset_s = wdata[COUNT_W-1:0];
            end else begin
                preset_s = preset_r;
            end
            case (state_r)
                ST_IDLE: begin
                    if (ctrl_r[0]) begin
                        state_s = ST_LOAD;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_LOAD: begin
                    // Uses the registered PRESET, so a same-cycle write lands next time.
                    count_s = preset_r;
                    state_s = ST_CNT;
                end
                ST_CNT: begin
                    if (!ctrl_r[0]) begin
                        state_s = ST_IDLE;
                    end else if (count_r > COUNT_W'(1)) begin
                        count_s = count_r - COUNT_W'(1);
                    end else begin
                        count_s    = '0;
                        irq_flag_s = 1'b1;
                        state_s    = ST_INT;
                    end
                end
                ST_INT: begin
                    state_s = ST_IDLE;
                    if (ctrl_r[2:1] == MODE_AUTO) begin
                        irq_flag_s = 1'b0;
                    end else begin
                        ctrl_s[0] = 1'b0;
                    end
                end
                default: begin
                    state_s = ST_IDLE;
                end
            endcase
        end
    end

    // State and register storage with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r    <= ST_IDLE;
            ctrl_r     <= 4'd0;
            preset_r   <= '0;
            count_r    <= '0;
            irq_flag_r <= 1'b0;
            irq_r      <= 1'b0;
        end else begin
            state_r    <= state_s;
            ctrl_r     <= ctrl_s;
            preset_r   <= preset_s;
            count_r    <= count_s;
            irq_flag_r <= irq_flag_s;
            irq_r      <= irq_flag_s & ctrl_s[3];
        end
    end

    // Zero-latency read mux over the register file.
    always_comb begin
        rdata = 32'd0;
        case (addr)
            ADDR_CTRL:   rdata = {28'd0, ctrl_r};
            ADDR_PRESET: rdata = 32'(preset_r);
            ADDR_COUNT:  rdata = 32'(count_r);
            default:     rdata = 32'd0;
        endcase
    end

    assign irq = irq_r;

endmodule

// File: tb/tb_timer_counter.sv
// Directed self-checking bench for timer_counter.
module tb_timer_counter;

    logic        clk;
    logic        reset;
    logic [1:0]  addr;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        irq;

    int checks = 0;
    int errors = 0;

    timer_counter #(.COUNT_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .addr  (addr),
        .we    (we),
        .wdata (wdata),
        .rdata (rdata),
        .irq   (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        addr  = a;
        wdata = d;
        we    = 1'b1;
        @(posedge clk);
        #1;
        we    = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        addr = a;
        #1;
        d = rdata;
    endtask

    task automatic test_reset();
        logic [31:0] v;
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        for (int a = 0; a < 3; a++) begin
            rd(2'(a), v);
            checks++;
            if (v !== 32'd0) begin
                errors++;
                $display("FAIL reset_read addr=%0d got=%h exp=%h", a, v, 32'd0);
            end
        end
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL reset_irq got=%b exp=0", irq);
        end
    endtask

    task automatic test_one_shot();
        logic [31:0] v;
        bit held;
        wr(2'd1, 32'd5);
        wr(2'd0, 32'h9);
        for (int e = 1; e <= 6; e++) tick();
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL oneshot_early got=%b exp=0", irq);
        end
        tick();
        checks++;
        if (irq !== 1'b1) begin
            errors++;
            $display("FAIL oneshot_rise got=%b exp=1", irq);
        end
        rd(2'd2, v);
        checks++;
        if (v !== 32'd0) begin
            errors++;
            $display("FAIL oneshot_count got=%h exp=0", v);
        end
        tick();
        rd(2'd0, v);
        checks++;
        if (v !== 32'h8) begin
            errors++;
            $display("FAIL oneshot_ctrl got=%h exp=8", v);
        end
        held = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (irq !== 1'b1) held = 1'b0;
        end
        checks++;
        if (held !== 1'b1) begin
            errors++;
            $display("FAIL oneshot_hold got=%b exp=1", held);
        end
        wr(2'd0, 32'h8);
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL oneshot_clear got=%b exp=0", irq);
        end
    endtask

    task automatic test_auto_reload();
        logic exp;
        wr(2'd1, 32'd3);
        wr(2'd0, 32'hB);
        for (int e = 1; e <= 24; e++) begin
            tick();
            exp = (e >= 5) && (((e - 5) % 6) == 0);
            checks++;
            if (irq !== exp) begin
                errors++;
                $display("FAIL auto_pulse edge=%0d got=%b exp=%b", e, irq, exp);
            end
        end
        wr(2'd0, 32'h0);
    endtask

    task automatic test_masked();
        logic [31:0] v;
        bit quiet;
        wr(2'd1, 32'd2);
        wr(2'd0, 32'h1);
        quiet = 1'b1;
        for (int e = 1; e <= 6; e++) begin
            tick();
            if (irq !== 1'b0) quiet = 1'b0;
        end
        checks++;
        if (quiet !== 1'b1) begin
            errors++;
            $display("FAIL masked_irq got=%b exp=1", quiet);
        end
        rd(2'd2, v);
        checks++;
        if (v !== 32'd0) begin
            errors++;
            $display("FAIL masked_count got=%h exp=0", v);
        end
        rd(2'd0, v);
        checks++;
        if (v !== 32'h0) begin
            errors++;
            $display("FAIL masked_ctrl got=%h exp=0", v);
        end
        wr(2'd0, 32'h9);
        for (int e = 1; e <= 3; e++) tick();
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL masked_restart_early got=%b exp=0", irq);
        end
        tick();
        checks++;
        if (irq !== 1'b1) begin
            errors++;
            $display("FAIL masked_restart_irq got=%b exp=1", irq);
        end
        wr(2'd0, 32'h0);
    endtask

    task automatic test_collisions();
        logic [31:0] v;
        wr(2'd1, 32'd3);
        wr(2'd0, 32'hB);
        tick();
        tick();
        wr(2'd1, 32'd9);
        rd(2'd2, v);
        checks++;
        if (v !== 32'd2) begin
            errors++;
            $display("FAIL coll_preset_count got=%h exp=2", v);
        end
        tick();
        tick();
        checks++;
        if (irq !== 1'b1) begin
            errors++;
            $display("FAIL coll_preset_irq got=%b exp=1", irq);
        end
        for (int e = 0; e < 3; e++) tick();
        rd(2'd2, v);
        checks++;
        if (v !== 32'd9) begin
            errors++;
            $display("FAIL coll_reload got=%h exp=9", v);
        end
        wr(2'd0, 32'h0);
        wr(2'd1, 32'd2);
        wr(2'd0, 32'h9);
        for (int e = 0; e < 3; e++) tick();
        wr(2'd0, 32'h8);
        rd(2'd2, v);
        checks++;
        if (v !== 32'd1) begin
            errors++;
            $display("FAIL coll_ctrl_count got=%h exp=1", v);
        end
        for (int e = 0; e < 3; e++) tick();
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL coll_ctrl_irq got=%b exp=0", irq);
        end
        rd(2'd2, v);
        checks++;
        if (v !== 32'd1) begin
            errors++;
            $display("FAIL coll_ctrl_frozen got=%h exp=1", v);
        end
    endtask

    task automatic test_edge_values();
        logic [31:0] v;
        wr(2'd1, 32'd0);
        wr(2'd0, 32'h9);
        tick();
        tick();
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL zero_preset_early got=%b exp=0", irq);
        end
        tick();
        checks++;
        if (irq !== 1'b1) begin
            errors++;
            $display("FAIL zero_preset_irq got=%b exp=1", irq);
        end
        wr(2'd0, 32'h0);
        wr(2'd2, 32'h55);
        wr(2'd3, 32'hFFFF_FFFF);
        rd(2'd2, v);
        checks++;
        if (v !== 32'd0) begin
            errors++;
            $display("FAIL count_write got=%h exp=0", v);
        end
        rd(2'd3, v);
        checks++;
        if (v !== 32'd0) begin
            errors++;
            $display("FAIL addr3_read got=%h exp=0", v);
        end
        rd(2'd1, v);
        checks++;
        if (v !== 32'd0) begin
            errors++;
            $display("FAIL addr3_alias got=%h exp=0", v);
        end
        wr(2'd0, 32'hFFFF_FFF8);
        rd(2'd0, v);
        checks++;
        if (v !== 32'h8) begin
            errors++;
            $display("FAIL ctrl_upper got=%h exp=8", v);
        end
        wr(2'd0, 32'h0);
        wr(2'd1, 32'd6);
        wr(2'd0, 32'h9);
        for (int e = 0; e < 4; e++) tick();
        rd(2'd2, v);
        checks++;
        if (v !== 32'd4) begin
            errors++;
            $display("FAIL midreset_pre got=%h exp=4", v);
        end
        reset = 1'b0;
        tick();
        reset = 1'b1;
        for (int a = 0; a < 3; a++) begin
            rd(2'(a), v);
            checks++;
            if (v !== 32'd0) begin
                errors++;
                $display("FAIL midreset_read addr=%0d got=%h exp=0", a, v);
            end
        end
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL midreset_irq got=%b exp=0", irq);
        end
    endtask

    initial begin
        reset = 1'b0;
        addr  = 2'd0;
        we    = 1'b0;
        wdata = 32'd0;
        test_reset();
        test_one_shot();
        test_auto_reload();
        test_masked();
        test_collisions();
        test_edge_values();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
